// File: rtl/c02_bus_responder.sv
// Byte-RAM bus responder for the 65C02 external bus: decodes a fixed address
// window and stretches each access with a programmable number of RDY wait states.
module c02_bus_responder #(
  parameter logic [15:0] ADDR_BASE   = 16'h0000,
  parameter int          AW          = 12,
  parameter int          WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rwb,
  input  logic        cpu_valid,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdy,
  output logic        cpu_hit,
  output logic [15:0] acc_count
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic [3:0] CNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit         ZERO_WAIT = (WAIT_STATES == 0);

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [15:0]   lat_addr;
  logic          lat_rwb;
  logic          hit;
  logic          mismatch;
  logic          latch;
  logic          complete;
  logic [AW-1:0] idx;
  logic [7:0]    mem [2**AW];

  // Decode is forced off during reset so nothing can hit, write or count.
  assign hit      = !rst && cpu_valid && (cpu_addr[15:AW] == ADDR_BASE[15:AW]);
  assign idx      = cpu_addr[AW-1:0];
  assign mismatch = !hit || (cpu_addr != lat_addr) || (cpu_rwb != lat_rwb);
  assign cpu_hit  = hit;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cpu_rdy   = 1'b1;
    latch     = 1'b0;
    complete  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hit) begin
          if (ZERO_WAIT) begin
            complete = 1'b1;
          end else begin
            cpu_rdy   = 1'b0;
            latch     = 1'b1;
            cnt_nxt   = CNT_INIT;
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mismatch) begin
          // Abort: a still-hitting new request restarts from IDLE next cycle.
          cpu_rdy   = !hit;
          state_nxt = ST_IDLE;
        end else if (cnt != 4'd0) begin
          cpu_rdy = 1'b0;
          cnt_nxt = cnt - 4'd1;
        end else begin
          complete  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cpu_rdata = (hit && cpu_rwb) ? mem[idx] : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      lat_addr  <= 16'h0000;
      lat_rwb   <= 1'b1;
      acc_count <= 16'h0000;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (latch) begin
        lat_addr <= cpu_addr;
        lat_rwb  <= cpu_rwb;
      end
      if (complete) acc_count <= acc_count + 16'd1;
    end
  end

  // RAM contents are never reset; only the completing cycle of a write updates them.
  always_ff @(posedge clk) begin
    if (complete && !cpu_rwb) mem[idx] <= cpu_wdata;
  end

endmodule
